// File: rtl/clk_period_meter.sv
// clk_period_meter: period and high-time meter for a slow square wave.
// Counts in system-clock cycles; flags loss of signal on counter overflow.
module clk_period_meter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in,
    output logic [W-1:0] period,
    output logic [W-1:0] high,
    output logic         valid,
    output logic         lost
);

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       state;
    logic         s1;
    logic         s2;
    logic         s3;
    logic [1:0]   fill;
    logic         primed;
    logic         rise;
    logic [W-1:0] cnt;
    logic [W-1:0] hcnt;
    logic [W-1:0] s2_ext;

    // s2 only reflects the real input once two edges have loaded it
    // since reset; before that its reset 0 must not count as "low".
    assign primed = fill[1];
    assign rise   = s2 & ~s3;
    assign s2_ext = {{(W-1){1'b0}}, s2};

    // Synchronizer chain and post-reset fill tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            fill <= 2'd0;
        end else begin
            s1 <= in;
            s2 <= s1;
            s3 <= s2;
            if (!fill[1]) begin
                fill <= fill + 2'd1;
            end
        end
    end

    // Measurement FSM with counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= WAIT_LOW;
            cnt    <= '0;
            hcnt   <= '0;
            period <= '0;
            high   <= '0;
            valid  <= 1'b0;
            lost   <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                WAIT_LOW: begin
                    if (primed && !s2) begin
                        state <= WAIT_EDGE;
                    end
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        hcnt  <= CNT_ONE;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period <= cnt;
                        high   <= hcnt;
                        valid  <= 1'b1;
                        lost   <= 1'b0;
                        cnt    <= CNT_ONE;
                        hcnt   <= CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        lost  <= 1'b1;
                        state <= WAIT_LOW;
                    end else begin
                        cnt  <= cnt + CNT_ONE;
                        hcnt <= hcnt + s2_ext;
                    end
                end
                default: begin
                    state <= WAIT_LOW;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed table-driven bench for clk_period_meter.
// Runs a W=16 and a W=4 instance side by side.
module tb_clk_period_meter;

    logic        clk = 1'b0;
    logic        rst16;
    logic        in16;
    logic [15:0] period16;
    logic [15:0] high16;
    logic        valid16;
    logic        lost16;
    logic        rst4;
    logic        in4;
    logic [3:0]  period4;
    logic [3:0]  high4;
    logic        valid4;
    logic        lost4;

    always #5 clk = ~clk;

    clk_period_meter #(.W(16)) dut16 (
        .clk(clk), .rst(rst16), .in(in16),
        .period(period16), .high(high16),
        .valid(valid16), .lost(lost16)
    );

    clk_period_meter #(.W(4)) dut4 (
        .clk(clk), .rst(rst4), .in(in4),
        .period(period4), .high(high4),
        .valid(valid4), .lost(lost4)
    );

    typedef struct {
        int          cyc;
        logic [15:0] p;
        logic [15:0] h;
        logic        l;
    } ev_t;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int ep;
        int eh;
        int en;
    } vec_t;

    ev_t q16[$];
    ev_t q4[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid16) q16.push_back(ev_t'{cyc, period16, high16, lost16});
        if (valid4)  q4.push_back(ev_t'{cyc, {12'd0, period4}, {12'd0, high4}, lost4});
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input bit sel, input logic v);
        if (sel) in4 = v;
        else     in16 = v;
    endtask

    task automatic reset_dut(input bit sel);
        if (sel) begin
            rst4 = 1'b1; in4 = 1'b0;
        end else begin
            rst16 = 1'b1; in16 = 1'b0;
        end
        tick(2);
        if (sel) begin
            chk("rst4.out", {period4, high4, valid4, lost4}, 0);
            rst4 = 1'b0;
        end else begin
            chk("rst16.out", {period16, high16, valid16, lost16}, 0);
            rst16 = 1'b0;
        end
        tick(6);
        if (sel) q4.delete();
        else     q16.delete();
    endtask

    task automatic drive(input bit sel, input int hi, input int lo,
                         input int reps, output int r1, output int r2);
        r1 = -1;
        r2 = -1;
        for (int i = 0; i < reps; i++) begin
            if (i == 0) r1 = cyc;
            if (i == 1) r2 = cyc;
            set_in(sel, 1'b1);
            tick(hi);
            set_in(sel, 1'b0);
            tick(lo);
        end
    endtask

    task automatic check_q(input bit sel, input string nm, input int en,
                           input int ep, input int eh, input int first);
        ev_t q[$];
        q = sel ? q4 : q16;
        chk({nm, ".count"}, q.size(), en);
        for (int i = 0; i < q.size() && i < en; i++) begin
            chk($sformatf("%s[%0d].period", nm, i), q[i].p, ep);
            chk($sformatf("%s[%0d].high", nm, i), q[i].h, eh);
            chk($sformatf("%s[%0d].lost", nm, i), q[i].l, 0);
            if (i == 0)
                chk($sformatf("%s.first_cyc", nm), q[i].cyc, first);
            else
                chk($sformatf("%s[%0d].spacing", nm, i), q[i].cyc - q[i-1].cyc, ep);
        end
    endtask

    initial begin
        vec_t vt[6];
        int   r1;
        int   r2;
        int   last;

        rst16 = 1'b1; in16 = 1'b0;
        rst4  = 1'b1; in4  = 1'b0;

        vt[0] = '{2, 2, 5,  4, 2, 4};
        vt[1] = '{3, 7, 4, 10, 3, 3};
        vt[2] = '{1, 1, 4,  2, 1, 3};
        vt[3] = '{5, 1, 3,  6, 5, 2};
        vt[4] = '{1, 9, 3, 10, 1, 2};
        vt[5] = '{7, 3, 3, 10, 7, 2};

        for (int i = 0; i < 6; i++) begin
            reset_dut(0);
            drive(0, vt[i].hi, vt[i].lo, vt[i].reps, r1, r2);
            tick(4);
            check_q(0, $sformatf("vec%0d", i), vt[i].en, vt[i].ep, vt[i].eh, r2 + 3);
            chk($sformatf("vec%0d.lost_end", i), lost16, 0);
        end

        // input high through reset: no false start
        rst16 = 1'b1; in16 = 1'b1;
        tick(3);
        rst16 = 1'b0;
        q16.delete();
        tick(20);
        chk("held.no_valid", q16.size(), 0);
        in16 = 1'b0;
        tick(3);
        drive(0, 3, 3, 4, r1, r2);
        tick(4);
        check_q(0, "held", 3, 6, 3, r2 + 3);

        // reset mid-measurement
        reset_dut(0);
        drive(0, 3, 7, 3, r1, r2);
        in16 = 1'b1;
        tick(2);
        rst16 = 1'b1;
        in16 = 1'b0;
        tick(1);
        chk("midrst.out", {period16, high16, valid16, lost16}, 0);
        rst16 = 1'b0;
        tick(6);
        q16.delete();
        drive(0, 3, 7, 3, r1, r2);
        tick(4);
        check_q(0, "midrst", 2, 10, 3, r2 + 3);

        // W=4: period 8 then loss of signal
        reset_dut(1);
        drive(1, 4, 4, 3, r1, r2);
        last = r1 + 16;
        tick(last + 17 - cyc);
        chk("w4_lost.before", lost4, 0);
        chk("w4_lost.before_period", period4, 8);
        tick(1);
        chk("w4_lost.set", lost4, 1);
        chk("w4_lost.held_period", period4, 8);
        chk("w4_lost.held_high", high4, 4);
        check_q(1, "w4_p8", 2, 8, 4, r2 + 3);

        // resume: first rise only restarts, next valid clears lost
        q4.delete();
        in4 = 1'b1;
        tick(4);
        in4 = 1'b0;
        tick(4);
        chk("w4_restart.lost", lost4, 1);
        chk("w4_restart.no_valid", q4.size(), 0);
        drive(1, 4, 4, 2, r1, r2);
        tick(4);
        check_q(1, "w4_resume", 2, 8, 4, r1 + 3);
        chk("w4_resume.lost", lost4, 0);

        // W=4: period 15 is the largest measurable
        reset_dut(1);
        drive(1, 5, 10, 3, r1, r2);
        tick(1);
        check_q(1, "w4_p15", 2, 15, 5, r2 + 3);
        chk("w4_p15.lost", lost4, 0);

        // W=4: period 16 overflows
        reset_dut(1);
        drive(1, 5, 11, 3, r1, r2);
        tick(2);
        chk("w4_p16.no_valid", q4.size(), 0);
        chk("w4_p16.lost", lost4, 1);
        chk("w4_p16.period", period4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow square wave, such as a divided clock, in units of the system clock. Each full period is reported as a one-cycle `valid` strobe with cycle-exact counts. It is the receiving end of the clock-divider path: it checks divider outputs in-system and on the bench. A loss-of-signal flag is raised when no edge arrives within the counter range.

## Interface
- `W`, default 16: width of the period and high-time counters; the maximum measurable period is 2^W-1 cycles.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  1  measured signal; asynchronous to `clk`.
- `period`  out  W  cycles between the last two rising edges of `in`.
- `high`  out  W  cycles that `in` was high within that period.
- `valid`  out  1  one-cycle strobe; `period` and `high` were updated on this edge.
- `lost`  out  1  sticky; no rising edge arrived within 2^W-1 cycles.

## Operation
- Synchronizer: `in` -> `s1` -> `s2` -> `s3`, all reset to 0.
  - `rise` = `s2 & ~s3`.
- Counters:
  - `cnt` (W bits) counts cycles since the last rise; the rise cycle counts as 1.
  - `hcnt` (W bits) counts cycles with `s2`=1 over the same span; `hcnt` ≤ `cnt` always, so it never overflows.
- State WAIT_LOW (entered on reset): wait for `s2`=0, then go to WAIT_EDGE. A signal that is high at reset release never produces a false start.
- State WAIT_EDGE: on `rise`, load `cnt`=1 and `hcnt`=1, then go to MEASURE. No output is produced.
- State MEASURE, on `rise`:
  - `period`<=`cnt`, `high`<=`hcnt`, `valid`<=1, `lost`<=0.
  - Reload `cnt`=1 and `hcnt`=1; stay in MEASURE.
- State MEASURE, no `rise`, `cnt` < 2^W-1:
  - `cnt`<=`cnt`+1, `hcnt`<=`hcnt`+`s2`.
- State MEASURE, no `rise`, `cnt` = 2^W-1:
  - `lost`<=1.
  - `period` and `high` hold their last values; no `valid`.
  - Go to WAIT_LOW.
- Simultaneous `rise` and `cnt` = 2^W-1: the rise wins. A valid measurement with `period` = 2^W-1 is reported and `lost` stays 0.
- After `lost`, the first rise only restarts measurement. `lost` clears together with the next `valid`.
- `rst` overrides everything:
  - All outputs, counters and synchronizer flops go to 0 and the state goes to WAIT_LOW on the same edge.
  - A measurement in progress is discarded.

## Timing
- Reset values: `period`=0, `high`=0, `valid`=0, `lost`=0.
- Latency: `valid` is asserted at the 3rd `clk` edge after the first edge that samples `in`=1.
  - Edge 1 loads `s1`.
  - Edge 2 loads `s2`; `rise` is combinational in the following cycle.
  - Edge 3 registers the outputs.
- `valid` is high for exactly one cycle per measured period. Strobes are at least 2 cycles apart, because the minimum detectable period is 2 cycles.
- For a periodic `in`, successive `valid` strobes are spaced exactly `period` cycles apart.
- `high` excludes synchronizer skew: both edges of `in` are delayed equally, so the count is exact to ±1 cycle of sampling jitter and exact for synchronous stimulus.
- Pulses shorter than 1 `clk` cycle may be missed; behaviour is undefined for them.

## Test plan
- Square wave, `in` toggling every 2 `clk` cycles (F0/F1 = 4), W=16 -> the second and later rises give `valid` every 4 cycles with `period`=4, `high`=2, `lost`=0.
- `in` high 3 and low 7 cycles, repeating -> `period`=10, `high`=3 on every `valid`; the first `valid` comes 3 edges after the second rising edge of `in`.
- `in`=1 held through reset and for 20 cycles after -> no `valid` and no WAIT_EDGE entry. Then `in` falls and toggles with period 6 and high 3 -> the first report is `period`=6, `high`=3.
- W=4: measure period 8, then hold `in`=0 -> `lost`=1 once 15 cycles have been counted, with `period`=8 still held. Then resume period 8 -> `lost` stays 1 through the first rise and clears with the next `valid` (`period`=8).
- W=4, period exactly 15 (high 5) -> `valid` with `period`=15, `high`=5, `lost` stays 0. Period 16 -> `lost`=1 and no `valid`.
- Assert `rst` for 1 cycle mid-measurement -> on the next edge all outputs are 0 and the state is WAIT_LOW. The first `valid` after release needs two fresh rising edges and reports the correct period.
